sprite_engine: RTL and testbench
================================

Name: sprite_engine

Overview:
Parametrised multi-sprite renderer for the VGA pixel pipeline. It compares the current beam coordinate against N_SPR independently positioned sprites and generates addresses for external synchronous sprite ROMs. It selects the highest-priority opaque pixel, maps the colour index to 4-bit RGB, and adds per-frame position latching, frame-based animation and sticky sprite-to-sprite collision detection.

Parameters:
N_SPR, 4, number of sprites (1..8); sprite 0 has highest priority
SPR_W, 64, sprite width in pixels (power of 2)
SPR_H, 64, sprite height in pixels (power of 2)
N_FRAMES, 4, animation frames stored per sprite ROM (power of 2)
ANIM_DIV, 8, frame_start pulses per animation step (>=1)
CI_W, 3, colour-index width; index 0 is transparent
ADDR_W, clog2(N_FRAMES*SPR_W*SPR_H), ROM address width (derived, default 14)

Ports:
clk  in  1  system clock (pixel clock domain)
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blanking
pix_valid  in  1  pixelx/pixely are in the active area
pixelx  in  10  beam x
pixely  in  10  beam y
posx  in  N_SPR*10  packed sprite top-left x, sprite i at [10i+9:10i]
posy  in  N_SPR*10  packed sprite top-left y
enable  in  N_SPR  per-sprite enable
anim_en  in  1  animation advance enable
rom_addr  out  N_SPR*ADDR_W  packed ROM addresses, one per sprite
rom_data  in  N_SPR*CI_W  packed ROM colour indices, valid 1 cycle after rom_addr
R  out  4  red
G  out  4  green
B  out  4  blue
visible  out  1  an opaque sprite pixel is output this cycle
hit_id  out  clog2(N_SPR)  index of the winning sprite (0 when !visible)
collision  out  1  previous frame contained an opaque overlap of >=2 sprites
anim_frame  out  clog2(N_FRAMES)  current animation frame

Behaviour:
- Reset (rst_n=0 at a clk edge): R/G/B/visible/hit_id/collision/anim_frame = 0. Shadow pos = 0. Shadow enable = 0, so nothing is drawn before the first frame_start. Divider = 0. Pipeline valid bits = 0. A reset mid-line kills in-flight pixels.
- Shadow registers: posx/posy/enable are captured only on a frame_start edge and used for the whole frame. When frame_start and pix_valid are both high, the pixel in that cycle uses the old shadow values.
- Animation: a divider counts frame_starts while anim_en=1. When it reaches ANIM_DIV-1 it clears and anim_frame increments mod N_FRAMES (wraps N_FRAMES-1 -> 0). With anim_en=0 the divider and frame hold.
- Stage 0 (cycle 0): for each sprite, dx = pixelx - sx and dy = pixely - sy (11-bit unsigned). in_box_i = en_i & pix_valid & pixelx>=sx & dx<SPR_W & pixely>=sy & dy<SPR_H. No horizontal or vertical wrap: a sprite at x=1000 is clipped at 1023. rom_addr_i = anim_frame*SPR_W*SPR_H + dy*SPR_W + dx, truncated to ADDR_W. rom_addr is driven even when in_box=0. in_box is registered.
- Stage 1 (cycle 1): rom_data valid. opaque_i = in_box_d_i & (rom_data_i != 0). Winner = lowest i with opaque_i.
- Stage 2 (registered outputs, cycle 2): visible = |opaque. Colour index c of the winner maps to R={4{c[2]}}, G={4{c[1]}}, B={4{c[0]}} (for CI_W>3 use the top 3 bits). When !visible: RGB=0, hit_id=0.
- Total latency: pixelx/pixely -> R/G/B/visible is 2 clk cycles. Throughput is 1 pixel per clock with no stalls.
- Collision: coll_live sets when 2 or more opaque_i are high in the same cycle. On frame_start: collision <= coll_live | (overlap in that same cycle), then coll_live <= 0. The collision output holds for the whole following frame.

Test Plan:
1. Reset, then enable=1, posx0=100, posy0=50, frame_start, ROM=const 5 -> pixel (100,50) gives visible=1, R=F,G=0,B=F exactly 2 cycles later; pixels (99,50) and (164,50) give visible=0.
2. Priority: sprites 0 and 1 at (200,200), ROM0=0 at offset (0,0), ROM1=3 -> visible=1, hit_id=1, RGB=0,F,F. Collision stays 0 because only one sprite is opaque.
3. Collision: both sprites opaque overlapping at (210,210) -> collision=0 during the frame; 1 after the next frame_start; 0 after the following frame_start if sprites are separated.
4. Position latching: change posx0 100->300 mid-frame -> drawing stays at 100 until frame_start, then moves to 300.
5. Animation: ANIM_DIV=8, anim_en=1, 32 frame_starts -> anim_frame steps 0,1,2,3,0. rom_addr at offset (0,0) with anim_frame=2 is 8192. anim_en=0 freezes the count.
6. Clipping and reset: posx=1000 draws x 1000..1023 and nothing at x 0..39. Assert rst_n=0 mid-line -> visible=0 next cycle and stays 0 until re-enable plus frame_start.

Source files
------------

// File: rtl/sprite_engine.sv
// Multi-sprite renderer: per-sprite box test and ROM addressing (stage 0),
// priority select of the opaque pixel (stage 1), registered RGB out (stage 2).
// Also holds per-frame shadow positions, the animation counter and the
// sticky collision flag.

// One sprite lane: box test and ROM address for the current beam position.
module sprite_lane #(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 14,
  parameter int FR_W   = 2
) (
  input  logic [9:0]        pixelx,
  input  logic [9:0]        pixely,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              en,
  input  logic              pix_valid,
  input  logic [FR_W-1:0]   frame,
  output logic              in_box,
  output logic [ADDR_W-1:0] rom_addr
);
  logic [10:0] dx, dy;

  // Unsigned offsets; the >= terms stop a negative offset aliasing into the box.
  always_comb begin
    dx       = {1'b0, pixelx} - {1'b0, sx};
    dy       = {1'b0, pixely} - {1'b0, sy};
    in_box   = en & pix_valid & (pixelx >= sx) & (dx < 11'(SPR_W))
                              & (pixely >= sy) & (dy < 11'(SPR_H));
    rom_addr = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
             + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
  end
endmodule

module sprite_engine #(
  parameter int N_SPR    = 4,
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 64,
  parameter int N_FRAMES = 4,
  parameter int ANIM_DIV = 8,
  parameter int CI_W     = 3,
  parameter int ADDR_W   = $clog2(N_FRAMES * SPR_W * SPR_H),
  localparam int HID_W   = (N_SPR > 1) ? $clog2(N_SPR) : 1,
  localparam int FR_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [9:0]               pixelx,
  input  logic [9:0]               pixely,
  input  logic [N_SPR*10-1:0]      posx,
  input  logic [N_SPR*10-1:0]      posy,
  input  logic [N_SPR-1:0]         enable,
  input  logic                     anim_en,
  output logic [N_SPR*ADDR_W-1:0]  rom_addr,
  input  logic [N_SPR*CI_W-1:0]    rom_data,
  output logic [3:0]               R,
  output logic [3:0]               G,
  output logic [3:0]               B,
  output logic                     visible,
  output logic [HID_W-1:0]         hit_id,
  output logic                     collision,
  output logic [FR_W-1:0]          anim_frame
);
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int CW3   = (CI_W > 3) ? CI_W : 3;

  logic [N_SPR-1:0][9:0] sx_q, sx_d, sy_q, sy_d;
  logic [N_SPR-1:0]      en_q, en_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [FR_W-1:0]       frame_q, frame_d;
  logic [N_SPR-1:0]      in_box, in_box_q, opaque;
  logic [HID_W-1:0]      win_id, hid_q, hid_d;
  logic [CI_W-1:0]       win_ci;
  logic [CW3-1:0]        ci_ext;
  logic [2:0]            ci_top;
  logic [11:0]           rgb_q, rgb_d;
  logic                  vis_q, vis_d, multi;
  logic                  coll_q, coll_d, coll_live_q, coll_live_d;

  for (genvar i = 0; i < N_SPR; i++) begin : g_lane
    sprite_lane #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .FR_W(FR_W)) u_lane (
      .pixelx    (pixelx),
      .pixely    (pixely),
      .sx        (sx_q[i]),
      .sy        (sy_q[i]),
      .en        (en_q[i]),
      .pix_valid (pix_valid),
      .frame     (frame_q),
      .in_box    (in_box[i]),
      .rom_addr  (rom_addr[i*ADDR_W +: ADDR_W])
    );
  end

  // Frame-rate state: shadow latch and animation divider, both on frame_start.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    en_d    = en_q;
    div_d   = div_q;
    frame_d = frame_q;
    if (frame_start) begin
      for (int i = 0; i < N_SPR; i++) begin
        sx_d[i] = posx[10*i +: 10];
        sy_d[i] = posy[10*i +: 10];
      end
      en_d = enable;
      if (anim_en) begin
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d   = '0;
          frame_d = (frame_q == FR_W'(N_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  // Stage 1: opaque mask, lowest-index winner and its colour expansion.
  always_comb begin
    opaque = '0;
    win_id = '0;
    win_ci = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      opaque[i] = in_box_q[i] & (rom_data[CI_W*i +: CI_W] != '0);
      if (opaque[i]) begin
        win_id = HID_W'(i);
        win_ci = rom_data[CI_W*i +: CI_W];
      end
    end
    multi  = |(opaque & (opaque - N_SPR'(1)));
    ci_ext = CW3'(win_ci);
    ci_top = ci_ext[CW3-1 -: 3];
    vis_d  = |opaque;
    hid_d  = win_id;
    rgb_d  = {{4{ci_top[2]}}, {4{ci_top[1]}}, {4{ci_top[0]}}};
  end

  // Collision: accumulate overlaps over a frame, publish at frame_start.
  always_comb begin
    coll_d      = coll_q;
    coll_live_d = coll_live_q | multi;
    if (frame_start) begin
      coll_d      = coll_live_q | multi;
      coll_live_d = 1'b0;
    end
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      en_q        <= '0;
      div_q       <= '0;
      frame_q     <= '0;
      in_box_q    <= '0;
      vis_q       <= 1'b0;
      hid_q       <= '0;
      rgb_q       <= '0;
      coll_q      <= 1'b0;
      coll_live_q <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      en_q        <= en_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
      in_box_q    <= in_box;
      vis_q       <= vis_d;
      hid_q       <= hid_d;
      rgb_q       <= rgb_d;
      coll_q      <= coll_d;
      coll_live_q <= coll_live_d;
    end
  end

  assign R          = rgb_q[11:8];
  assign G          = rgb_q[7:4];
  assign B          = rgb_q[3:0];
  assign visible    = vis_q;
  assign hit_id     = hid_q;
  assign collision  = coll_q;
  assign anim_frame = frame_q;
endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: a reference pixel model pushes the
// expected output per driven pixel; a monitor pops it two clocks later.
module tb_sprite_engine;
  localparam int N = 4, AW = 14, CW = 3;

  logic          clk = 1'b0;
  logic          rst_n, frame_start, pix_valid, anim_en;
  logic [9:0]    pixelx, pixely;
  logic [N*10-1:0] posx, posy;
  logic [N-1:0]  enable;
  logic [N*AW-1:0] rom_addr;
  logic [N*CW-1:0] rom_data;
  logic [3:0]    R, G, B;
  logic          visible, collision;
  logic [1:0]    hit_id, anim_frame;

  always #5 clk = ~clk;

  sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pixelx(pixelx), .pixely(pixely), .posx(posx), .posy(posy), .enable(enable),
    .anim_en(anim_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .R(R), .G(G), .B(B), .visible(visible), .hit_id(hit_id),
    .collision(collision), .anim_frame(anim_frame)
  );

  // Synchronous ROMs: each sprite returns a constant colour index.
  logic [CW-1:0] rom_val [N];
  always @(posedge clk)
    for (int i = 0; i < N; i++) rom_data[i*CW +: CW] <= rom_val[i];

  typedef struct {
    int          due;
    logic        vis;
    logic [1:0]  hid;
    logic [11:0] rgb;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int sh_x[N], sh_y[N];
  logic sh_en[N];
  int m_div = 0, m_frame = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop every expectation that is due now and compare with the outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (mon_e.due != cyc) begin
        n_fail++;
        $display("FAIL sb_late due=%0d now=%0d", mon_e.due, cyc);
      end else if (visible !== mon_e.vis || hit_id !== mon_e.hid || {R, G, B} !== mon_e.rgb) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d got vis=%b hid=%0d rgb=%h exp vis=%b hid=%0d rgb=%h",
                 cyc, visible, hit_id, {R, G, B}, mon_e.vis, mon_e.hid, mon_e.rgb);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one pixel cycle, push the model's expectation, then update model state.
  task automatic set_pix(input int x, input int y, input bit pv, input bit fs);
    exp_t e;
    logic [2:0] c;
    bit found = 0;
    pixelx = 10'(x); pixely = 10'(y); pix_valid = pv; frame_start = fs;
    e.due = cyc + 2; e.vis = 0; e.hid = 0; e.rgb = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && sh_en[i] && pv && x >= sh_x[i] && x - sh_x[i] < 64 &&
          y >= sh_y[i] && y - sh_y[i] < 64 && rom_val[i] != 0) begin
        found = 1; c = rom_val[i];
        e.vis = 1; e.hid = 2'(i);
        e.rgb = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
      end
    end
    sb.push_back(e);
    if (fs) begin
      for (int i = 0; i < N; i++) begin
        sh_x[i] = int'(posx[i*10 +: 10]);
        sh_y[i] = int'(posy[i*10 +: 10]);
        sh_en[i] = enable[i];
      end
      if (anim_en) begin
        if (m_div == 7) begin m_div = 0; m_frame = (m_frame + 1) % 4; end
        else m_div++;
      end
    end
  endtask

  task automatic drive_pix(input int x, input int y, input bit pv, input bit fs);
    set_pix(x, y, pv, fs);
    tick();
  endtask

  task automatic frame_pulse();
    drive_pix(0, 0, 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    pix_valid = 0; frame_start = 0;
    while (sb.size() > 0 && k < 10) begin tick(); k++; end
    n_tests++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end
  endtask

  task automatic set_sprite(input int i, input int x, input int y);
    posx[i*10 +: 10] = 10'(x);
    posy[i*10 +: 10] = 10'(y);
  endtask

  task automatic do_reset();
    rst_n = 0; pix_valid = 0; frame_start = 0;
    repeat (3) tick();
    rst_n = 1;
    sb.delete();
    for (int i = 0; i < N; i++) begin sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; end
    m_div = 0; m_frame = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({visible, R, G, B, hit_id, collision} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_out got=%h required=0", {visible, R, G, B, hit_id, collision});
    end
    n_tests++;
    if (anim_frame !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_anim got=%0d required=0", anim_frame);
    end
    // Enabled inputs but no frame_start yet: nothing may be drawn.
    enable = 4'hF;
    for (int i = 0; i < N; i++) rom_val[i] = 3'd7;
    drive_pix(0, 0, 1, 0);
    drive_pix(5, 5, 1, 0);
    drain();
  endtask

  task automatic test_basic();
    enable = 4'b0001; set_sprite(0, 100, 50);
    rom_val[0] = 3'd5;
    frame_pulse();
    drive_pix(100, 50, 1, 0);
    drive_pix(99, 50, 1, 0);
    drive_pix(164, 50, 1, 0);
    drive_pix(163, 113, 1, 0);
    drive_pix(100, 114, 1, 0);
    drive_pix(130, 80, 0, 0);
    drive_pix(130, 80, 1, 0);
    drain();
  endtask

  task automatic test_priority();
    enable = 4'b0011; set_sprite(0, 200, 200); set_sprite(1, 200, 200);
    rom_val[0] = 3'd0; rom_val[1] = 3'd3;
    frame_pulse();
    drive_pix(200, 200, 1, 0);
    drive_pix(263, 263, 1, 0);
    drive_pix(264, 200, 1, 0);
    drain();
    frame_pulse();
    n_tests++;
    if (collision !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_prio got=%b required=0", collision);
    end
  endtask

  task automatic test_collision();
    rom_val[0] = 3'd5; rom_val[1] = 3'd3;
    set_sprite(1, 180, 180);
    frame_pulse();
    drive_pix(150, 150, 1, 0);
    drain();
    n_tests++;
    if (collision !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_during got=%b required=0", collision);
    end
    // Overlap pixel immediately followed by frame_start: same-cycle capture.
    set_sprite(1, 500, 500);
    drive_pix(210, 210, 1, 0);
    frame_pulse();
    n_tests++;
    if (collision !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_set got=%b required=1", collision);
    end
    drive_pix(210, 210, 1, 0);
    drive_pix(500, 500, 1, 0);
    drain();
    n_tests++;
    if (collision !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_hold got=%b required=1", collision);
    end
    frame_pulse();
    n_tests++;
    if (collision !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_clear got=%b required=0", collision);
    end
    drain();
  endtask

  task automatic test_latch();
    enable = 4'b0001; set_sprite(0, 100, 50); rom_val[0] = 3'd5;
    frame_pulse();
    set_sprite(0, 300, 50);
    drive_pix(100, 50, 1, 0);
    drive_pix(300, 50, 1, 0);
    drive_pix(100, 50, 1, 1);
    drive_pix(100, 50, 1, 0);
    drive_pix(300, 50, 1, 0);
    drain();
  endtask

  task automatic test_anim();
    set_sprite(0, 100, 50);
    frame_pulse();
    anim_en = 1;
    for (int k = 1; k <= 40; k++) begin
      frame_pulse();
      n_tests++;
      if (anim_frame !== 2'(m_frame)) begin
        n_fail++;
        $display("FAIL anim_step k=%0d got=%0d required=%0d", k, anim_frame, m_frame);
      end
      if (k == 16) begin
        set_pix(100, 50, 1, 0); #1;
        n_tests++;
        if (rom_addr[AW-1:0] !== 14'd8192) begin
          n_fail++;
          $display("FAIL addr_org got=%0d required=8192", rom_addr[AW-1:0]);
        end
        tick();
        set_pix(103, 52, 1, 0); #1;
        n_tests++;
        if (rom_addr[AW-1:0] !== 14'd8323) begin
          n_fail++;
          $display("FAIL addr_off got=%0d required=8323", rom_addr[AW-1:0]);
        end
        tick();
      end
      if (k == 32) begin
        n_tests++;
        if (anim_frame !== 2'd0) begin
          n_fail++;
          $display("FAIL anim_wrap got=%0d required=0", anim_frame);
        end
      end
    end
    anim_en = 0;
    repeat (16) frame_pulse();
    n_tests++;
    if (anim_frame !== 2'd1) begin
      n_fail++;
      $display("FAIL anim_freeze got=%0d required=1", anim_frame);
    end
    anim_en = 1;
    repeat (8) frame_pulse();
    n_tests++;
    if (anim_frame !== 2'd2) begin
      n_fail++;
      $display("FAIL anim_resume got=%0d required=2", anim_frame);
    end
    anim_en = 0;
    drain();
  endtask

  task automatic test_clip_reset();
    enable = 4'b0001; set_sprite(0, 1000, 100); rom_val[0] = 3'd6;
    frame_pulse();
    drive_pix(1000, 100, 1, 0);
    drive_pix(1023, 163, 1, 0);
    drive_pix(999, 100, 1, 0);
    drive_pix(0, 100, 1, 0);
    drive_pix(20, 100, 1, 0);
    drive_pix(39, 100, 1, 0);
    drive_pix(1023, 164, 1, 0);
    drain();
    // In-flight opaque pixel killed by a reset.
    pixelx = 10'd1010; pixely = 10'd120; pix_valid = 1;
    tick();
    rst_n = 0; pix_valid = 0;
    tick();
    n_tests++;
    if (visible !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_kill got=%b required=0", visible);
    end
    rst_n = 1;
    for (int i = 0; i < N; i++) begin sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; end
    m_div = 0; m_frame = 0;
    repeat (3) drive_pix(1010, 120, 1, 0);
    frame_pulse();
    drive_pix(1010, 120, 1, 0);
    drain();
  endtask

  initial begin
    rst_n = 0; frame_start = 0; pix_valid = 0; anim_en = 0;
    pixelx = '0; pixely = '0; posx = '0; posy = '0; enable = '0;
    for (int i = 0; i < N; i++) rom_val[i] = '0;
    test_reset();
    test_basic();
    test_priority();
    test_collision();
    test_latch();
    test_anim();
    test_clip_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
